// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// A single full-subtractor cell is time-shared across the word, with the borrow kept in a register.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;

    logic a_bit, b_bit, d_bit, borrow_nx;

    // Full-subtractor cell operating on the current LSBs of the operand shifters.
    always_comb begin
        a_bit     = a_sh_q[0];
        b_bit     = b_sh_q[0];
        d_bit     = a_bit ^ b_bit ^ borrow_q;
        borrow_nx = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d   = A;
                    b_sh_d   = B;
                    borrow_d = Bin;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                borrow_d = borrow_nx;
                // Result bits enter at the MSB; after WIDTH shifts the first bit sits at bit 0.
                diff_d   = {d_bit, diff_q[WIDTH-1:1]};
                if (cnt_q == LAST_BIT) begin
                    bout_d  = borrow_nx;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
        end
    end

    assign ready = (state_q == S_IDLE);
    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign Diff  = diff_q;
    assign Bout  = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, reset abort, ignored starts,
// exhaustive back-to-back sweep and random traffic against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 4;
    localparam int TMO = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in, b_in;
    logic         bin_in;
    logic         ready, busy, done;
    logic [W-1:0] diff;
    logic         bout;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .Bin   (bin_in),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .Diff  (diff),
        .Bout  (bout)
    );

    always #5 clk = ~clk;

    // Reference: plain integer subtraction; borrow-out from the unsigned comparison.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bi);
        int r;
        logic [W-1:0] d;
        logic bo;
        r  = int'(a) - int'(b) - int'(bi);
        d  = W'(r & ((1 << W) - 1));
        bo = (int'(a) < int'(b) + int'(bi));
        return {bo, d};
    endfunction

    // Drives one operation (waiting for ready first) and returns the observed result and
    // the number of edges from the accepting edge to the first cycle with done high.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                         output logic [W-1:0] d, output logic bo, output int lat);
        int k;
        k = 0;
        while (ready !== 1'b1 && k < TMO) begin
            @(negedge clk);
            k++;
        end
        start  = 1'b1;
        a_in   = a;
        b_in   = b;
        bin_in = bi;
        @(negedge clk);
        start  = 1'b0;
        a_in   = W'($urandom);
        b_in   = W'($urandom);
        bin_in = 1'($urandom);
        lat = 0;
        while (done !== 1'b1 && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        d  = diff;
        bo = bout;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        a_in = '0;
        b_in = '0;
        bin_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({ready, busy, done, diff, bout} !== {1'b1, 1'b0, 1'b0, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset: rdy/busy/done/diff/bout = %b/%b/%b/%h/%b, want 1/0/0/0/0",
                     ready, busy, done, diff, bout);
        end
        $display("reset: rdy=%b busy=%b done=%b diff=%h bout=%b", ready, busy, done, diff, bout);
    endtask

    task automatic test_basic();
        logic [W-1:0] d;
        logic bo;
        int lat;
        do_op(4'd5, 4'd3, 1'b0, d, bo, lat);
        checks++;
        if (lat !== W) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges, want %0d", lat, W);
        end
        checks++;
        if ({bo, d} !== 5'b0_0010) begin
            errors++;
            $display("FAIL basic_result: got diff=%h bout=%b, want diff=2 bout=0", d, bo);
        end
        @(negedge clk);
        checks++;
        if ({ready, done, busy} !== 3'b100) begin
            errors++;
            $display("FAIL basic_after_done: rdy/done/busy=%b%b%b, want 100", ready, done, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({bout, diff} !== 5'b0_0010) begin
            errors++;
            $display("FAIL basic_hold: got diff=%h bout=%b, want diff=2 bout=0", diff, bout);
        end
        $display("basic: 5-3-0 -> diff=%h bout=%b lat=%0d", d, bo, lat);
    endtask

    task automatic test_borrow_cases();
        logic [W-1:0] ta [4] = '{4'h3, 4'h0, 4'hF, 4'hF};
        logic [W-1:0] tb [4] = '{4'h5, 4'h0, 4'hF, 4'h0};
        logic         tbi[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [W:0]   texp[4] = '{5'b1_1110, 5'b1_1111, 5'b0_0000, 5'b0_1110};
        logic [W-1:0] d;
        logic bo;
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], tbi[i], d, bo, lat);
            checks++;
            if ({bo, d} !== texp[i] || lat !== W) begin
                errors++;
                $display("FAIL edge_case%0d: got diff=%h bout=%b lat=%0d, want diff=%h bout=%b lat=%0d",
                         i, d, bo, lat, texp[i][W-1:0], texp[i][W], W);
            end
            $display("edge_case%0d: %h-%h-%b -> diff=%h bout=%b", i, ta[i], tb[i], tbi[i], d, bo);
        end
    endtask

    task automatic test_ignore_start();
        int ndone;
        int k;
        logic [W-1:0] d_seen;
        logic bo_seen;
        k = 0;
        while (ready !== 1'b1 && k < TMO) begin
            @(negedge clk);
            k++;
        end
        start = 1'b1; a_in = 4'd9; b_in = 4'd2; bin_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a_in = 4'd1; b_in = 4'd7; bin_in = 1'b0;
        @(negedge clk);
        start = 1'b0; a_in = W'($urandom); b_in = W'($urandom);
        ndone = 0;
        d_seen = '0;
        bo_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (done === 1'b1) begin
                ndone++;
                d_seen = diff;
                bo_seen = bout;
            end
            @(negedge clk);
        end
        checks++;
        if (ndone !== 1 || {bo_seen, d_seen} !== 5'b0_0111) begin
            errors++;
            $display("FAIL ignore_start: got %0d done pulses diff=%h bout=%b, want 1 pulse diff=7 bout=0",
                     ndone, d_seen, bo_seen);
        end
        $display("ignore_start: dones=%0d diff=%h bout=%b", ndone, d_seen, bo_seen);
    endtask

    task automatic test_reset_abort();
        int ndone;
        int lat;
        int k;
        k = 0;
        while (ready !== 1'b1 && k < TMO) begin
            @(negedge clk);
            k++;
        end
        start = 1'b1; a_in = 4'd8; b_in = 4'd1; bin_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        @(negedge clk);
        if (done === 1'b1) ndone++;
        @(negedge clk);
        if (done === 1'b1) ndone++;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        rst = 1'b0;
        checks++;
        if (ndone !== 0 || {ready, busy, done, diff, bout} !== {1'b1, 1'b0, 1'b0, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_abort: dones=%0d rdy/busy/done/diff/bout=%b/%b/%b/%h/%b, want 0 1/0/0/0/0",
                     ndone, ready, busy, done, diff, bout);
        end
        start = 1'b1; a_in = 4'd8; b_in = 4'd1; bin_in = 1'b0;
        lat = 0;
        @(negedge clk);
        while (done !== 1'b1 && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if ({bout, diff} !== 5'b0_0111 || lat !== W) begin
            errors++;
            $display("FAIL held_start_result: diff=%h bout=%b lat=%0d, want diff=7 bout=0 lat=%0d",
                     diff, bout, lat, W);
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL held_start_ready: ready=%b, want 1", ready);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL held_start_restart: busy=%b, want 1", busy);
        end
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
        $display("reset_abort: dones during abort=%0d, held start restarted busy ok", ndone);
    endtask

    task automatic test_exhaustive();
        logic [W-1:0] d;
        logic bo;
        logic [W:0] exp;
        int lat;
        int bad;
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            logic [W-1:0] a, b;
            logic bi;
            a  = W'(i >> 5);
            b  = W'(i >> 1);
            bi = 1'(i);
            exp = ref_sub(a, b, bi);
            do_op(a, b, bi, d, bo, lat);
            checks++;
            if ({bo, d} !== exp || lat !== W) begin
                errors++;
                bad++;
                $display("FAIL exhaustive %h-%h-%b: got diff=%h bout=%b lat=%0d, want diff=%h bout=%b lat=%0d",
                         a, b, bi, d, bo, lat, exp[W-1:0], exp[W], W);
            end
        end
        $display("exhaustive: 512 ops, %0d bad", bad);
    endtask

    task automatic test_random();
        logic [W-1:0] d;
        logic bo;
        logic [W:0] exp;
        int lat;
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a, b;
            logic bi;
            a  = W'($urandom);
            b  = W'($urandom);
            bi = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            exp = ref_sub(a, b, bi);
            do_op(a, b, bi, d, bo, lat);
            checks++;
            if ({bo, d} !== exp || lat !== W) begin
                errors++;
                $display("FAIL random %h-%h-%b: got diff=%h bout=%b lat=%0d, want diff=%h bout=%b lat=%0d",
                         a, b, bi, d, bo, lat, exp[W-1:0], exp[W], W);
            end
            $display("random %0d: %h-%h-%b -> diff=%h bout=%b", i, a, b, bi, d, bo);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_borrow_cases();
        test_ignore_start();
        test_reset_abort();
        test_exhaustive();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
